// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state enum, the row-drive table and the key-code width.
package keypad_pkg;

   localparam int KEY_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   // Active-low one-hot row drive, indexed by row number.
   localparam logic [3:0] ROW_DRIVE [4] = '{
      4'b1110, 4'b1101, 4'b1011, 4'b0111
   };

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs.
// Ports: clk, rst_n (async active-low, resets to all ones), d (async in), q (synced out).
module sync2 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with whole-scan debounce and valid/ack output.
// Ports: clk, rst_n, ROWSEL (row drive), COL (raw columns), key_code/key_valid/key_ack,
// key_held (accepted key still down), key_overrun (press accepted over an unread key).
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [3:0]       ROWSEL,
   input  logic [3:0]       COL,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   input  logic             key_ack,
   output logic             key_held,
   output logic             key_overrun
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
   localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   logic [3:0]       col_s;
   logic [DW-1:0]    dwell;
   logic [1:0]       row;
   logic             sample;
   logic             eos;
   logic             acc_hit;
   logic [KEY_W-1:0] acc_code;
   logic             col_hit;
   logic [1:0]       col_idx;
   logic             prev_hit;
   logic             scan_hit;
   logic [KEY_W-1:0] scan_code;

   state_t           state;
   state_t           state_n;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_n;
   logic [KEY_W-1:0] cand;
   logic [KEY_W-1:0] cand_n;
   logic             accept;
   logic             release_key;

   sync2 #(.W(4)) u_col_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (COL),
      .q     (col_s)
   );

   assign sample = (dwell == DWELL_LAST);
   assign eos    = sample && (row == 2'd3);

   // Lowest low column wins within a row.
   assign col_hit = ~&col_s;
   always_comb begin
      col_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!col_s[i]) col_idx = 2'(i);
      end
   end

   // Row 0 starts a fresh scan; earlier rows of this scan have priority.
   assign prev_hit  = acc_hit && (row != 2'd0);
   assign scan_hit  = prev_hit || col_hit;
   assign scan_code = prev_hit ? acc_code : {row, col_idx};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell    <= '0;
         row      <= 2'd0;
         ROWSEL   <= 4'b1110;
         acc_hit  <= 1'b0;
         acc_code <= '0;
      end else if (sample) begin
         dwell    <= '0;
         row      <= row + 2'd1;
         ROWSEL   <= ROW_DRIVE[row + 2'd1];
         acc_hit  <= scan_hit;
         acc_code <= scan_code;
      end else begin
         dwell <= dwell + DWELL_ONE;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cand_n      = cand;
      accept      = 1'b0;
      release_key = 1'b0;
      if (eos) begin
         unique case (state)
            IDLE: begin
               if (scan_hit) begin
                  cand_n = scan_code;
                  if (CNT_DONE == CNT_ONE) begin
                     accept  = 1'b1;
                     state_n = HELD;
                     cnt_n   = '0;
                  end else begin
                     state_n = DEBOUNCE;
                     cnt_n   = CNT_ONE;
                  end
               end
            end
            DEBOUNCE: begin
               if (scan_hit && (scan_code == cand)) begin
                  if (cnt + CNT_ONE == CNT_DONE) begin
                     accept  = 1'b1;
                     state_n = HELD;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + CNT_ONE;
                  end
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end
            HELD: begin
               if (!scan_hit) begin
                  if (CNT_DONE == CNT_ONE) begin
                     release_key = 1'b1;
                     state_n     = IDLE;
                     cnt_n       = '0;
                  end else begin
                     state_n = RELEASE;
                     cnt_n   = CNT_ONE;
                  end
               end
            end
            RELEASE: begin
               if (!scan_hit) begin
                  if (cnt + CNT_ONE == CNT_DONE) begin
                     release_key = 1'b1;
                     state_n     = IDLE;
                     cnt_n       = '0;
                  end else begin
                     cnt_n = cnt + CNT_ONE;
                  end
               end else begin
                  state_n = HELD;
                  cnt_n   = '0;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cand  <= cand_n;
      end
   end

   // An accept overrides a same-cycle ack; overrun only if the old key was not taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_code    <= '0;
         key_valid   <= 1'b0;
         key_held    <= 1'b0;
         key_overrun <= 1'b0;
      end else begin
         key_overrun <= 1'b0;
         if (accept) begin
            key_code    <= cand_n;
            key_valid   <= 1'b1;
            key_held    <= 1'b1;
            key_overrun <= key_valid && !key_ack;
         end else if (key_valid && key_ack) begin
            key_valid <= 1'b0;
         end
         if (release_key) key_held <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A keypad model drives COL from ROWSEL; a monitor pops expected codes per report.
module tb_keypad_scanner;

   logic       clk;
   logic       rst_n;
   logic [3:0] ROWSEL;
   logic [3:0] COL;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ack;
   logic       key_held;
   logic       key_overrun;

   logic [15:0] pressed;
   logic        auto_ack;
   int          exp_q[$];
   int          n_checks;
   int          n_fail;
   int          n_ovr;
   logic [3:0]  rows [4];

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ROWSEL      (ROWSEL),
      .COL         (COL),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_ack     (key_ack),
      .key_held    (key_held),
      .key_overrun (key_overrun)
   );

   function automatic logic [3:0] col_model(input logic [3:0] rs, input logic [15:0] keys);
      logic [3:0] c;
      c = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!rs[r]) begin
            for (int cc = 0; cc < 4; cc++) begin
               if (keys[r*4+cc]) c[cc] = 1'b0;
            end
         end
      end
      return c;
   endfunction

   assign COL = col_model(ROWSEL, pressed);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic align_scan();
      logic [3:0] prev;
      bit         ok;
      ok   = 1'b0;
      prev = ROWSEL;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (prev == 4'b0111 && ROWSEL == 4'b1110) begin
            ok = 1'b1;
            break;
         end
         prev = ROWSEL;
      end
      if (!ok) check("scan_timeout", 0, 1);
   endtask

   task automatic scans(input int n);
      for (int i = 0; i < n; i++) align_scan();
   endtask

   task automatic ack_once();
      key_ack = 1'b1;
      @(posedge clk);
      #1;
      key_ack = 1'b0;
   endtask

   task automatic release_all();
      align_scan();
      pressed = '0;
      scans(3);
   endtask

   // Ack responder: when enabled, acks whatever is presented.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (auto_ack) key_ack = key_valid;
      end
   end

   // Monitor: a report is a rising valid, an overrun, or valid surviving an ack.
   initial begin
      logic pv;
      logic pa;
      int   e;
      pv = 1'b0;
      pa = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0;
            pa = 1'b0;
         end else begin
            if (key_overrun) n_ovr++;
            if (key_valid && (!pv || key_overrun || pa)) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_report: got code %0d, none expected", key_code);
               end else begin
                  e = exp_q.pop_front();
                  if (int'(key_code) != e) begin
                     n_fail++;
                     $display("FAIL report_code: got %0d expected %0d", key_code, e);
                  end
               end
            end
            pv = key_valid;
            pa = key_ack;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rows     = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      n_checks = 0;
      n_fail   = 0;
      n_ovr    = 0;
      rst_n    = 1'b0;
      key_ack  = 1'b0;
      auto_ack = 1'b0;
      pressed  = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_rowsel", int'(ROWSEL), 4'b1110);
      check("reset_valid", int'(key_valid), 0);
      check("reset_held", int'(key_held), 0);
      check("reset_code", int'(key_code), 0);
      check("reset_overrun", int'(key_overrun), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         check("rowsel_cycle", int'(ROWSEL), int'(rows[(k/4)%4]));
      end
      scans(2);

      // Single press of key 6 with manual ack.
      align_scan();
      pressed[6] = 1'b1;
      exp_q.push_back(6);
      scans(2);
      check("single_not_early", int'(key_valid), 0);
      scans(1);
      check("single_valid", int'(key_valid), 1);
      check("single_code", int'(key_code), 6);
      check("single_held", int'(key_held), 1);
      ack_once();
      check("ack_clears", int'(key_valid), 0);
      align_scan();
      pressed = '0;
      scans(2);
      check("release_not_early", int'(key_held), 1);
      scans(1);
      check("release_held", int'(key_held), 0);

      // Bounce on key 9.
      auto_ack = 1'b1;
      align_scan();
      pressed[9] = 1'b1;
      exp_q.push_back(9);
      scans(2);
      pressed = '0;
      scans(1);
      pressed[9] = 1'b1;
      scans(2);
      check("bounce_not_early", int'(key_held), 0);
      scans(1);
      check("bounce_held", int'(key_held), 1);
      check("bounce_code", int'(key_code), 9);
      release_all();
      check("bounce_release", int'(key_held), 0);

      // Keys 13 and 4 together resolve to 4.
      pressed[13] = 1'b1;
      pressed[4]  = 1'b1;
      exp_q.push_back(4);
      scans(3);
      check("multi_code", int'(key_code), 4);
      scans(3);
      pressed[13] = 1'b0;
      scans(3);
      check("multi_still_held", int'(key_held), 1);
      pressed = '0;
      scans(3);
      check("multi_release", int'(key_held), 0);

      // Overrun: key 1 then key 15 with no ack.
      auto_ack = 1'b0;
      key_ack  = 1'b0;
      align_scan();
      pressed[1] = 1'b1;
      exp_q.push_back(1);
      scans(3);
      check("ovr_first_code", int'(key_code), 1);
      pressed = '0;
      scans(3);
      pressed[15] = 1'b1;
      exp_q.push_back(15);
      scans(3);
      check("ovr_pulse", int'(key_overrun), 1);
      check("ovr_code", int'(key_code), 15);
      check("ovr_valid", int'(key_valid), 1);
      @(posedge clk);
      #1;
      check("ovr_one_cycle", int'(key_overrun), 0);
      release_all();

      // Ack coincident with accept of key 2.
      pressed[2] = 1'b1;
      exp_q.push_back(2);
      scans(2);
      repeat (15) @(posedge clk);
      #1;
      key_ack = 1'b1;
      @(posedge clk);
      #1;
      key_ack = 1'b0;
      check("ackacc_valid", int'(key_valid), 1);
      check("ackacc_code", int'(key_code), 2);
      check("ackacc_no_ovr", int'(key_overrun), 0);
      ack_once();
      check("ackacc_cleared", int'(key_valid), 0);
      release_all();

      // Reset mid-debounce with key 5 held throughout.
      pressed[5] = 1'b1;
      scans(2);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_rowsel", int'(ROWSEL), 4'b1110);
      check("midrst_code", int'(key_code), 0);
      check("midrst_valid", int'(key_valid), 0);
      exp_q.push_back(5);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (47) @(posedge clk);
      #1;
      check("midrst_not_early", int'(key_valid), 0);
      @(posedge clk);
      #1;
      check("midrst_valid_after", int'(key_valid), 1);
      check("midrst_code_after", int'(key_code), 5);
      ack_once();
      pressed = '0;
      scans(4);

      check("queue_empty", exp_q.size(), 0);
      check("overrun_count", n_ovr, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
